// File: rtl/i2s_slave_transceiver_pkg.sv
// Shared constants and types for the I2S slave transceiver: channel encoding on ws,
// default word/synchroniser sizes and the lock state type.
package i2s_slave_transceiver_pkg;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  localparam int D_WIDTH_DEF     = 24;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/i2s_slave_transceiver_if.sv
// I2S serial bus pins. The external master owns sclk/ws/sd_rx; the slave drives sd_tx.
interface i2s_slave_transceiver_if;

  logic sclk;
  logic ws;
  logic sd_rx;
  logic sd_tx;

  modport master (
    output sclk,
    output ws,
    output sd_rx,
    input  sd_tx
  );

  modport slave (
    input  sclk,
    input  ws,
    input  sd_rx,
    output sd_tx
  );

endinterface

// File: rtl/i2s_slave_transceiver_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with registered rise/fall strobes
// that line up with the registered level output.
module i2s_slave_transceiver_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_p0;
  logic              lvl_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      lvl_p1  <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[STAGES-2:0], d};
      // stage p1: edge detect on the last synchroniser flop
      lvl_p1  <= sync_p0[STAGES-1];
      rise    <= sync_p0[STAGES-1] & ~lvl_p1;
      fall    <= ~sync_p0[STAGES-1] & lvl_p1;
    end
  end

  assign q = lvl_p1;

endmodule

// File: rtl/i2s_slave_transceiver.sv
// I2S slave endpoint: oversamples an externally clocked I2S bus in the mclk domain,
// deserialises left/right words from sd_rx and serialises the tx pair onto sd_tx.
module i2s_slave_transceiver
  import i2s_slave_transceiver_pkg::*;
#(
  parameter int DATA_W = D_WIDTH_DEF,
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic                mclk,
  input  logic                reset,
  i2s_slave_transceiver_if.slave i2s,
  input  logic [DATA_W-1:0]   l_data_tx,
  input  logic [DATA_W-1:0]   r_data_tx,
  output logic                tx_load,
  output logic [DATA_W-1:0]   l_data_rx,
  output logic [DATA_W-1:0]   r_data_rx,
  output logic                rx_valid,
  output logic                frame_err,
  output logic                locked
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic sclk_lvl_unused;
  logic ws_rise_unused, ws_fall_unused, sd_rise_unused, sd_fall_unused;
  logic rise_p2, fall_p2, ws_p2, sd_p2;

  lock_state_t state_q, state_d;

  logic              ws_prev;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_hold_r;
  logic [DATA_W-1:0] tx_shift;
  logic [CNT_W-1:0]  tx_cnt;
  logic              sd_tx_q;
  logic              boundary;

  i2s_slave_transceiver_sync_edge #(.STAGES(STAGES)) u_sync_sclk (
    .clk(mclk), .reset(reset), .d(i2s.sclk),
    .q(sclk_lvl_unused), .rise(rise_p2), .fall(fall_p2)
  );

  i2s_slave_transceiver_sync_edge #(.STAGES(STAGES)) u_sync_ws (
    .clk(mclk), .reset(reset), .d(i2s.ws),
    .q(ws_p2), .rise(ws_rise_unused), .fall(ws_fall_unused)
  );

  i2s_slave_transceiver_sync_edge #(.STAGES(STAGES)) u_sync_sd (
    .clk(mclk), .reset(reset), .d(i2s.sd_rx),
    .q(sd_p2), .rise(sd_rise_unused), .fall(sd_fall_unused)
  );

  assign boundary = rise_p2 && (ws_p2 != ws_prev);

  always_ff @(posedge mclk) begin
    if (reset) state_q <= ST_UNLOCKED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (boundary) state_d = ST_LOCKED;
  end

  assign locked = (state_q == ST_LOCKED);

  always_ff @(posedge mclk) begin
    if (reset) begin
      ws_prev   <= WS_LEFT;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_hold_r <= '0;
      tx_shift  <= '0;
      tx_cnt    <= '0;
      sd_tx_q   <= 1'b0;
      l_data_rx <= '0;
      r_data_rx <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      tx_load   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      tx_load   <= 1'b0;
      // stage p3: act on synchronised sclk edges
      if (rise_p2) begin
        ws_prev <= ws_p2;
        if (boundary) begin
          if (locked) begin
            if (ws_prev == WS_LEFT) begin
              l_data_rx <= rx_shift;
            end else begin
              r_data_rx <= rx_shift;
              rx_valid  <= 1'b1;
            end
            if (bit_cnt < CNT_FULL) frame_err <= 1'b1;
          end
          bit_cnt  <= '0;
          rx_shift <= '0;
          tx_cnt   <= '0;
          // Left word goes straight to the shifter; only the right word needs holding.
          if (ws_p2 == WS_LEFT) begin
            tx_hold_r <= r_data_tx;
            tx_shift  <= l_data_tx;
            tx_load   <= 1'b1;
          end else begin
            tx_shift  <= tx_hold_r;
          end
        end else if (locked && (bit_cnt < CNT_FULL)) begin
          rx_shift <= {rx_shift[DATA_W-2:0], sd_p2};
          bit_cnt  <= bit_cnt + 1'b1;
        end
      end
      if (fall_p2 && locked) begin
        if (tx_cnt < CNT_FULL) begin
          sd_tx_q  <= tx_shift[DATA_W-1];
          tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          tx_cnt   <= tx_cnt + 1'b1;
        end else begin
          sd_tx_q  <= 1'b0;
        end
      end
    end
  end

  assign i2s.sd_tx = sd_tx_q;

endmodule

// File: tb/tb_i2s_slave_transceiver.sv
// Directed bench: acts as the external I2S master (32-bit slots, sclk = mclk/4) and checks
// received words, transmitted words, pulses, lock, reset and stalled-clock behaviour.
module tb_i2s_slave_transceiver;

  localparam int DW = 24;

  logic          mclk  = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] l_data_tx = '0;
  logic [DW-1:0] r_data_tx = '0;
  logic [DW-1:0] l_data_rx, r_data_rx;
  logic          tx_load, rx_valid, frame_err, locked;

  i2s_slave_transceiver_if io ();

  i2s_slave_transceiver #(.DATA_W(DW), .STAGES(2)) dut (
    .mclk      (mclk),
    .reset     (reset),
    .i2s       (io),
    .l_data_tx (l_data_tx),
    .r_data_tx (r_data_tx),
    .tx_load   (tx_load),
    .l_data_rx (l_data_rx),
    .r_data_rx (r_data_rx),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .locked    (locked)
  );

  always #5 mclk = ~mclk;

  int          n_chk = 0;
  int          n_err = 0;
  int          rxv_cnt = 0, ferr_cnt = 0, load_cnt = 0, chg_cnt = 0;
  logic        sd_last = 1'b0;
  logic [47:0] rxq[$];
  logic [47:0] expq[$];
  bit          jitter = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] q_at(input int i);
    if (i < rxq.size()) return rxq[i];
    return '1;
  endfunction

  always @(negedge mclk) begin
    if (rx_valid) begin
      rxq.push_back({l_data_rx, r_data_rx});
      rxv_cnt++;
    end
    if (frame_err) ferr_cnt++;
    if (tx_load) load_cnt++;
    if (io.sd_tx !== sd_last) chg_cnt++;
    sd_last = io.sd_tx;
  end

  task automatic half_wait();
    int h;
    h = jitter ? int'($urandom_range(3, 2)) : 2;
    repeat (h) @(negedge mclk);
  endtask

  // One slot: period 0 carries the ws change, data MSB-first from period 1.
  // sd_tx sampled at fall p belongs to the bit launched at fall p-1.
  task automatic send_slot(input logic ws_v, input logic [DW-1:0] d, input int nbits,
                           input int len, input int rst_at, input int stall_at,
                           output logic [DW-1:0] txw, output logic zero_ok);
    logic smp, bitv;
    int   s_ev, s_chg;
    txw = '0;
    zero_ok = 1'b1;
    for (int p = 0; p < len; p++) begin
      bitv = (p >= 1 && p <= nbits) ? d[5'(nbits - p)] : 1'b0;
      smp  = io.sd_tx;
      if (p >= 2 && p <= 25) txw = {txw[DW-2:0], smp};
      else if (p >= 26 && smp) zero_ok = 1'b0;
      io.sclk  = 1'b0;
      io.ws    = ws_v;
      io.sd_rx = bitv;
      if (p == rst_at) reset = 1'b1;
      half_wait();
      reset   = 1'b0;
      io.sclk = 1'b1;
      half_wait();
      if (p == stall_at) begin
        repeat (8) @(negedge mclk);
        s_ev  = rxv_cnt + ferr_cnt + load_cnt;
        s_chg = chg_cnt;
        repeat (1000) @(negedge mclk);
        check("stall_pulses", 64'(rxv_cnt + ferr_cnt + load_cnt - s_ev), 64'd0);
        check("stall_sdtx_chg", 64'(chg_cnt - s_chg), 64'd0);
      end
    end
  endtask

  initial begin
    logic [DW-1:0] tl, tr, ltx, rtx, rl, rr;
    logic          zl, zr;
    int            ld0;

    io.sclk = 1'b0; io.ws = 1'b0; io.sd_rx = 1'b0;
    repeat (4) @(negedge mclk);
    reset = 1'b0;
    @(negedge mclk);
    check("rst_locked", locked, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_tx_load", tx_load, 0);
    check("rst_l_rx", l_data_rx, 0);
    check("rst_r_rx", r_data_rx, 0);
    check("rst_sd_tx", io.sd_tx, 0);

    // Frames of A5A5A5/3C3C3C in, 800001/7FFFFE out
    l_data_tx = 24'h800001;
    r_data_tx = 24'h7FFFFE;
    for (int f = 1; f <= 3; f++) begin
      send_slot(1'b0, 24'hA5A5A5, 24, 32, -1, -1, tl, zl);
      if (f == 1) check("f1_unlocked", locked, 0);
      send_slot(1'b1, 24'h3C3C3C, 24, 32, -1, -1, tr, zr);
      if (f == 1) begin
        check("f1_locked", locked, 1);
        check("f1_tx_l", tl, 0);
        check("f1_tx_r_zero", tr, 0);
      end else begin
        check("tx_l", tl, 24'h800001);
        check("tx_r", tr, 24'h7FFFFE);
        check("tx_l_pad_zero", zl, 1);
        check("tx_r_pad_zero", zr, 1);
      end
    end

    // Short left word (16 bits), then a full right word
    send_slot(1'b0, 24'h00BEEF, 16, 17, -1, -1, tl, zl);
    send_slot(1'b1, 24'h123456, 24, 32, -1, -1, tr, zr);
    check("short_frame_err", ferr_cnt, 1);
    check("short_l_rx", l_data_rx, 24'h00BEEF);

    // Reset in the middle of a left word
    send_slot(1'b0, 24'h5A5A5A, 24, 32, 10, -1, tl, zl);
    check("rxq_count", rxq.size(), 4);
    check("rx_pair0", q_at(0), {24'h000000, 24'h3C3C3C});
    check("rx_pair1", q_at(1), {24'hA5A5A5, 24'h3C3C3C});
    check("rx_pair2", q_at(2), {24'hA5A5A5, 24'h3C3C3C});
    check("rx_pair_short", q_at(3), {24'h00BEEF, 24'h123456});
    check("tx_load_count", load_cnt, 4);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_l_rx", l_data_rx, 0);
    check("mid_rst_r_rx", r_data_rx, 0);
    check("mid_rst_sd_tx", io.sd_tx, 0);

    rxq.delete();
    send_slot(1'b1, 24'hC0FFEE, 24, 32, -1, -1, tl, tr);
    check("relock", locked, 1);
    send_slot(1'b0, 24'h13579B, 24, 32, -1, -1, tl, zl);
    send_slot(1'b1, 24'h2468AC, 24, 32, -1, -1, tr, zr);
    check("relock_tx_l", tl, 24'h800001);
    check("relock_tx_r", tr, 24'h7FFFFE);
    check("relock_rxq_count", rxq.size(), 1);
    check("relock_rx_pair", q_at(0), {24'h000000, 24'hC0FFEE});
    check("relock_no_ferr", ferr_cnt, 1);

    // Random data with sclk half-period jitter
    rxq.delete();
    expq.delete();
    expq.push_back({24'h13579B, 24'h2468AC});
    ld0 = load_cnt;
    jitter = 1'b1;
    for (int f = 0; f < 100; f++) begin
      ltx = DW'($urandom); rtx = DW'($urandom);
      rl  = DW'($urandom); rr  = DW'($urandom);
      l_data_tx = ltx;
      r_data_tx = rtx;
      send_slot(1'b0, rl, 24, 32, -1, -1, tl, zl);
      send_slot(1'b1, rr, 24, 32, -1, -1, tr, zr);
      check("rand_tx_l", tl, ltx);
      check("rand_tx_r", tr, rtx);
      expq.push_back({rl, rr});
    end
    jitter = 1'b0;
    send_slot(1'b0, 24'h000000, 24, 32, -1, -1, tl, zl);
    check("rand_rxq_count", rxq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) check("rand_rx_pair", q_at(i), expq[i]);
    check("rand_tx_load_count", load_cnt - ld0, 101);
    check("rand_no_ferr", ferr_cnt, 1);

    // sclk held high for 1000 mclk in the middle of a right word
    rxq.delete();
    send_slot(1'b1, 24'h0F0F0F, 24, 32, -1, 12, tl, tr);
    check("stall_tx_r", tl, r_data_tx);
    send_slot(1'b0, 24'h000000, 0, 2, -1, -1, tr, zr);
    repeat (8) @(negedge mclk);
    check("stall_rxq_count", rxq.size(), 1);
    check("stall_rx_pair", q_at(0), {24'h000000, 24'h0F0F0F});
    check("stall_no_ferr", ferr_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
